// File: rtl/count_day_pkg.sv
// Shared constants, BCD day type and BCD helpers for the day-of-month stage.
package count_day_pkg;

    localparam int UNIT_W = 4;
    localparam int TEN_W  = 2;

    // Day value as two BCD digits, tens in the upper bits.
    typedef struct packed {
        logic [TEN_W-1:0]  ten;
        logic [UNIT_W-1:0] unit;
    } bcd_day_t;

    localparam logic [UNIT_W-1:0] DAY_FIRST_UNIT = 4'd1;
    localparam logic [TEN_W-1:0]  DAY_FIRST_TEN  = 2'd0;
    localparam logic [UNIT_W-1:0] DAYS_28_UNIT   = 4'd8;
    localparam logic [TEN_W-1:0]  DAYS_28_TEN    = 2'd2;
    localparam logic [UNIT_W-1:0] DAYS_29_UNIT   = 4'd9;
    localparam logic [TEN_W-1:0]  DAYS_29_TEN    = 2'd2;
    localparam logic [UNIT_W-1:0] DAYS_30_UNIT   = 4'd0;
    localparam logic [TEN_W-1:0]  DAYS_30_TEN    = 2'd3;
    localparam logic [UNIT_W-1:0] DAYS_31_UNIT   = 4'd1;
    localparam logic [TEN_W-1:0]  DAYS_31_TEN    = 2'd3;

    localparam bcd_day_t DAY_FIRST = '{ten: DAY_FIRST_TEN, unit: DAY_FIRST_UNIT};
    localparam bcd_day_t DAYS_28   = '{ten: DAYS_28_TEN,   unit: DAYS_28_UNIT};
    localparam bcd_day_t DAYS_29   = '{ten: DAYS_29_TEN,   unit: DAYS_29_UNIT};
    localparam bcd_day_t DAYS_30   = '{ten: DAYS_30_TEN,   unit: DAYS_30_UNIT};
    localparam bcd_day_t DAYS_31   = '{ten: DAYS_31_TEN,   unit: DAYS_31_UNIT};

    // a >= b on two-digit BCD values (tens digit dominates).
    function automatic logic bcd_ge(input bcd_day_t a, input bcd_day_t b);
        logic res;
        if (a.ten > b.ten) begin
            res = 1'b1;
        end else if (a.ten == b.ten) begin
            res = (a.unit >= b.unit);
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // BCD increment: units 9 rolls to 0 and carries into tens.
    function automatic bcd_day_t bcd_inc(input bcd_day_t a);
        bcd_day_t res;
        if (a.unit == 4'd9) begin
            res.unit = 4'd0;
            res.ten  = a.ten + 2'd1;
        end else begin
            res.unit = a.unit + 4'd1;
            res.ten  = a.ten;
        end
        return res;
    endfunction

    // BCD decrement: units 0 rolls to 9 and borrows from tens.
    function automatic bcd_day_t bcd_dec(input bcd_day_t a);
        bcd_day_t res;
        if (a.unit == 4'd0) begin
            res.unit = 4'd9;
            res.ten  = a.ten - 2'd1;
        end else begin
            res.unit = a.unit - 4'd1;
            res.ten  = a.ten;
        end
        return res;
    endfunction

endpackage

// File: rtl/count_day_limit_dec.sv
// Combinational last-day-of-month decoder: February (28/29) beats 30-day
// months, which beat 31-day months; with no flag set the month is taken as 31.
module day_limit_dec
    import count_day_pkg::*;
(
    input  logic              TO,
    input  logic              T,
    input  logic              TN,
    input  logic              leap,
    output logic [TEN_W-1:0]  o_last_ten,
    output logic [UNIT_W-1:0] o_last_unit
);

    bcd_day_t w_last;

    // Priority decode of the month-length flags into the last legal day.
    always_comb begin
        w_last = DAYS_31;
        if (TN) begin
            if (leap) begin
                w_last = DAYS_29;
            end else begin
                w_last = DAYS_28;
            end
        end else if (T) begin
            w_last = DAYS_30;
        end else if (TO) begin
            w_last = DAYS_31;
        end else begin
            w_last = DAYS_31;
        end
    end

    assign o_last_ten  = w_last.ten;
    assign o_last_unit = w_last.unit;

endmodule

// File: rtl/count_day.sv
// Day-of-month BCD counter. Advances on the hour-stage carry, accepts manual
// up/down setting when no carry is pending, and clamps to the last day of the
// month whenever the month or leap flags shrink the month under the current day.
module count_day
    import count_day_pkg::*;
#(
    parameter int MAX_DISPLAY_UNIT = UNIT_W,
    parameter int MAX_DISPLAY_TEN  = TEN_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_d,
    input  logic                        up,
    input  logic                        down,
    input  logic                        TO,
    input  logic                        T,
    input  logic                        TN,
    input  logic                        leap,
    output logic [MAX_DISPLAY_UNIT-1:0] day_unit,
    output logic [MAX_DISPLAY_TEN-1:0]  day_ten,
    output logic                        pulse_d
);

    bcd_day_t r_day;
    bcd_day_t w_day_next;
    bcd_day_t w_last;
    logic     w_at_last;    // D >= L
    logic     w_past_last;  // D >  L
    logic     w_is_first;   // D == 01

    day_limit_dec u_limit (
        .TO          (TO),
        .T           (T),
        .TN          (TN),
        .leap        (leap),
        .o_last_ten  (w_last.ten),
        .o_last_unit (w_last.unit)
    );

    assign w_at_last   = bcd_ge(r_day, w_last);
    assign w_past_last = w_at_last && (r_day != w_last);
    assign w_is_first  = (r_day == DAY_FIRST);

    // Next-day selection: carry strobe first, then exclusive up or down, else clamp/hold.
    always_comb begin
        w_day_next = r_day;
        if (en_d) begin
            if (w_at_last) begin
                w_day_next = DAY_FIRST;
            end else begin
                w_day_next = bcd_inc(r_day);
            end
        end else if (up && !down) begin
            if (w_at_last) begin
                w_day_next = DAY_FIRST;
            end else begin
                w_day_next = bcd_inc(r_day);
            end
        end else if (down && !up) begin
            if (w_is_first || w_past_last) begin
                w_day_next = w_last;
            end else begin
                w_day_next = bcd_dec(r_day);
            end
        end else begin
            if (w_past_last) begin
                w_day_next = w_last;
            end else begin
                w_day_next = r_day;
            end
        end
    end

    // Day register; reset forces day 01 without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_day <= DAY_FIRST;
        end else begin
            r_day <= w_day_next;
        end
    end

    // The month advances exactly when a carry arrives on the last day.
    assign pulse_d  = rst_n & en_d & w_at_last;

    assign day_unit = MAX_DISPLAY_UNIT'(r_day.unit);
    assign day_ten  = MAX_DISPLAY_TEN'(r_day.ten);

endmodule

// File: tb/tb_count_day.sv
// Directed table-driven bench for count_day plus hand-written reset sequences.
module tb_count_day;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en_d  = 1'b0;
    logic       up    = 1'b0;
    logic       down  = 1'b0;
    logic       to_f  = 1'b0;
    logic       t_f   = 1'b0;
    logic       tn_f  = 1'b0;
    logic       leap  = 1'b0;
    logic [3:0] day_unit;
    logic [1:0] day_ten;
    logic       pulse_d;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic en;
        logic up_i;
        logic dn;
        logic to_i;
        logic t_i;
        logic tn_i;
        logic lp;
        logic exp_pulse;
        int   exp_d;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    count_day #(.MAX_DISPLAY_UNIT(4), .MAX_DISPLAY_TEN(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_d     (en_d),
        .up       (up),
        .down     (down),
        .TO       (to_f),
        .T        (t_f),
        .TN       (tn_f),
        .leap     (leap),
        .day_unit (day_unit),
        .day_ten  (day_ten),
        .pulse_d  (pulse_d)
    );

    function automatic void add(input logic en, input logic u, input logic d,
                                input logic a, input logic b, input logic c,
                                input logic lp, input logic p, input int dd);
        vec_t v;
        v.en = en; v.up_i = u; v.dn = d; v.to_i = a; v.t_i = b; v.tn_i = c;
        v.lp = lp; v.exp_pulse = p; v.exp_d = dd;
        tbl.push_back(v);
    endfunction

    task automatic check_d(input string name, input int idx, input int exp_d);
        logic [1:0] et;
        logic [3:0] eu;
        et = 2'(exp_d / 10);
        eu = 4'(exp_d % 10);
        n_vec++;
        if (day_ten !== et || day_unit !== eu) begin
            n_err++;
            $display("FAIL %s[%0d]: day got ten=%0d unit=%0d, expected ten=%0d unit=%0d",
                     name, idx, day_ten, day_unit, et, eu);
        end
    endtask

    task automatic check_p(input string name, input int idx, input logic exp_p);
        n_vec++;
        if (pulse_d !== exp_p) begin
            n_err++;
            $display("FAIL %s[%0d]: pulse_d got %b, expected %b", name, idx, pulse_d, exp_p);
        end
    endtask

    task automatic step(input string name, input int idx, input vec_t v);
        @(negedge clk);
        en_d = v.en; up = v.up_i; down = v.dn;
        to_f = v.to_i; t_f = v.t_i; tn_f = v.tn_i; leap = v.lp;
        #1;
        check_p(name, idx, v.exp_pulse);
        @(posedge clk);
        #1;
        check_d(name, idx, v.exp_d);
    endtask

    initial begin
        vec_t v;

        // Asynchronous reset with a carry strobe pending.
        #1;
        rst_n = 1'b0; en_d = 1'b1; to_f = 1'b1;
        #1;
        check_d("rst_async", 0, 1);
        check_p("rst_pulse", 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_d("rst_hold", 0, 1);
        check_p("rst_hold_pulse", 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1; en_d = 1'b0;

        // Full 31-day month driven by carry strobes.
        for (int k = 1; k <= 31; k++) begin
            v.en = 1'b1; v.up_i = 1'b0; v.dn = 1'b0; v.to_i = 1'b1; v.t_i = 1'b0;
            v.tn_i = 1'b0; v.lp = 1'b0;
            v.exp_pulse = (k == 31);
            v.exp_d = (k == 31) ? 1 : k + 1;
            step("month31", k, v);
        end

        //  en up dn  TO T  TN lp  pulse day
        add(0, 0, 1,  1, 0, 0, 0,  0, 31);  // down at 01 loads L
        add(0, 0, 0,  0, 1, 0, 0,  0, 30);  // idle clamp to 30
        add(0, 0, 0,  0, 0, 1, 0,  0, 28);  // idle clamp to 28
        add(0, 0, 0,  1, 0, 0, 0,  0, 28);  // idle hold
        add(0, 1, 1,  1, 0, 0, 0,  0, 28);  // up=down hold
        add(0, 1, 0,  1, 0, 0, 0,  0, 29);
        add(0, 1, 0,  1, 0, 0, 0,  0, 30);
        add(0, 1, 0,  1, 0, 0, 0,  0, 31);
        add(0, 1, 1,  0, 1, 0, 0,  0, 30);  // up=down clamp
        add(0, 1, 1,  0, 0, 1, 0,  0, 28);
        add(0, 1, 1,  0, 0, 1, 1,  0, 28);  // leap: 28 under 29, hold
        add(0, 1, 0,  0, 0, 1, 0,  0, 1);   // up wrap, no pulse
        add(0, 0, 1,  0, 0, 1, 0,  0, 28);
        add(1, 0, 0,  0, 0, 1, 0,  1, 1);   // Feb 28 carry wraps
        add(0, 0, 1,  0, 0, 1, 0,  0, 28);
        add(1, 0, 0,  0, 0, 1, 1,  0, 29);  // leap year continues
        add(1, 0, 0,  0, 0, 1, 1,  1, 1);
        add(0, 0, 1,  0, 1, 0, 0,  0, 30);  // down at 01, 30-day month
        add(1, 0, 0,  1, 0, 0, 0,  0, 31);  // flag change with carry uses new L
        add(0, 0, 1,  0, 1, 0, 0,  0, 30);  // down above L clamps
        add(0, 0, 1,  0, 1, 0, 0,  0, 29);  // BCD borrow
        add(0, 1, 0,  0, 1, 0, 0,  0, 30);  // BCD carry
        add(0, 0, 0,  0, 1, 1, 0,  0, 28);  // TN has priority over T
        add(0, 1, 0,  0, 1, 0, 0,  0, 29);
        add(0, 1, 0,  0, 1, 0, 0,  0, 30);
        add(0, 1, 0,  0, 1, 0, 0,  0, 1);   // up at 30 wraps, no pulse
        for (int d = 2; d <= 9; d++) add(0, 1, 0, 0, 1, 0, 0, 0, d);
        add(0, 1, 0,  0, 1, 0, 0,  0, 10);  // 09 -> 10
        add(0, 0, 1,  0, 1, 0, 0,  0, 9);   // 10 -> 09
        add(0, 1, 0,  0, 1, 0, 0,  0, 10);
        for (int d = 11; d <= 16; d++) add(1, 1, 0, 1, 0, 0, 0, 0, d);  // carry beats up
        add(1, 0, 1,  1, 0, 0, 0,  0, 17);  // carry beats down
        add(1, 0, 0,  0, 0, 0, 0,  0, 18);  // no flag means 31-day month
        add(1, 0, 0,  1, 0, 0, 0,  0, 19);
        add(1, 0, 0,  1, 0, 0, 0,  0, 20);
        add(0, 0, 0,  0, 0, 0, 0,  0, 20);  // idle hold

        foreach (tbl[i]) begin
            step("table", i, tbl[i]);
        end

        // Reset in the middle of a carry strobe at day 20.
        @(negedge clk);
        en_d = 1'b1; up = 1'b0; down = 1'b0; to_f = 1'b1; t_f = 1'b0; tn_f = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_d("rst_mid", 0, 1);
        check_p("rst_mid_pulse", 0, 1'b0);
        @(posedge clk);
        #1;
        check_d("rst_mid_edge", 0, 1);
        check_p("rst_mid_edge_pulse", 0, 1'b0);
        #1;
        rst_n = 1'b1;
        v.en = 1'b1; v.up_i = 1'b0; v.dn = 1'b0; v.to_i = 1'b1; v.t_i = 1'b0;
        v.tn_i = 1'b0; v.lp = 1'b0; v.exp_pulse = 1'b0; v.exp_d = 2;
        step("post_rst", 0, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
